// File: rtl/aes_key_sched_buf.sv
// AES key schedule engine: expands 128/192/256-bit keys one word per cycle into
// per-slot round-key buffers that the cipher core reads in either round order.

module aes_sbox_lut (
    input  logic       inv_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);
    // Entry x lives at bit position (255-x)*8, so the table reads in natural order.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data_o = SBOX[{~data_i, 3'b000} +: 8];
        if (inv_i) begin
            data_o = 8'h00;
            for (int k = 0; k < 256; k++) begin
                if (SBOX[k*8 +: 8] == data_i) data_o = ~8'(k);
            end
        end
    end
endmodule

module aes_key_sched_buf #(
    parameter bit          AES192Enable = 1'b1,
    parameter int unsigned NumSlots     = 2,
    parameter int unsigned SlotW        = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [SlotW-1:0] slot_i,
    input  logic [2:0]       key_len_i,
    input  logic [255:0]     key_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic [SlotW-1:0] rd_slot_i,
    input  logic [3:0]       rd_round_i,
    input  logic             rd_dir_i,
    output logic [127:0]     rd_key_o,
    output logic             rd_valid_o
);
    typedef enum logic [1:0] {KEY_128, KEY_192, KEY_256} key_len_e;
    typedef enum logic {IDLE, EXPAND} state_e;

    function automatic logic [3:0] nk_of(key_len_e l);
        case (l)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_e l);
        case (l)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(key_len_e l);
        case (l)
            KEY_192: return 6'd52;
            KEY_256: return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic logic slot_in_range(logic [SlotW-1:0] s);
        return 32'(s) < NumSlots;
    endfunction

    logic [31:0]         words_q [NumSlots][60];
    logic [NumSlots-1:0] valid_q;
    key_len_e            len_q   [NumSlots];

    state_e              state_q;
    logic [SlotW-1:0]    cur_slot_q;
    key_len_e            cur_len_q;
    logic [5:0]          idx_q;
    logic [2:0]          mod_q;
    logic [7:0]          rcon_q;

    // Start/clear qualification
    logic     len_legal;
    key_len_e len_dec;
    logic     start_ok, start_err, clear_ok, abort, last, finish;

    always_comb begin
        len_legal = 1'b1;
        len_dec   = KEY_128;
        case (key_len_i)
            3'b001:  len_dec = KEY_128;
            3'b010: begin
                len_dec   = KEY_192;
                len_legal = AES192Enable;
            end
            3'b100:  len_dec = KEY_256;
            default: len_legal = 1'b0;
        endcase
    end

    assign clear_ok  = clear_i && slot_in_range(slot_i);
    assign start_ok  = start_i && !clear_i && state_q == IDLE && len_legal && slot_in_range(slot_i);
    assign start_err = start_i && !clear_i && !start_ok;
    assign abort     = clear_ok && state_q == EXPAND && slot_i == cur_slot_q;
    assign last      = idx_q == nw_of(cur_len_q) - 6'd1;
    assign finish    = state_q == EXPAND && last && !abort;

    // Word generation datapath: one shared 4-S-box SubWord
    logic [31:0] temp, w_back, rot, sub_in, sub_out, f_word, new_word;

    assign temp   = words_q[cur_slot_q][idx_q - 6'd1];
    assign w_back = words_q[cur_slot_q][idx_q - 6'(nk_of(cur_len_q))];
    assign rot    = {temp[23:0], temp[31:24]};
    assign sub_in = (mod_q == 3'd0) ? rot : temp;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox_lut u_sbox (
            .inv_i  (1'b0),
            .data_i (sub_in[b*8 +: 8]),
            .data_o (sub_out[b*8 +: 8])
        );
    end

    always_comb begin
        f_word = temp;
        if (mod_q == 3'd0)                              f_word = sub_out ^ {rcon_q, 24'h0};
        else if (cur_len_q == KEY_256 && mod_q == 3'd4) f_word = sub_out;
    end

    assign new_word = w_back ^ f_word;

    // Read path: resolves against post-edge state so a finishing slot reads valid at once
    logic         rd_ok;
    logic [3:0]   rd_nr, rd_r;
    logic [5:0]   rd_base;
    logic [127:0] rd_key_d;

    always_comb begin
        rd_ok    = 1'b0;
        rd_nr    = 4'd10;
        rd_r     = 4'd0;
        rd_key_d = '0;
        if (slot_in_range(rd_slot_i)) begin
            rd_nr = nr_of(len_q[rd_slot_i]);
            rd_ok = valid_q[rd_slot_i];
            if (finish && cur_slot_q == rd_slot_i)  rd_ok = 1'b1;
            if (start_ok && slot_i == rd_slot_i)    rd_ok = 1'b0;
            if (clear_ok && slot_i == rd_slot_i)    rd_ok = 1'b0;
            if (rd_round_i > rd_nr)                 rd_ok = 1'b0;
        end
        if (rd_ok) rd_r = rd_dir_i ? rd_nr - rd_round_i : rd_round_i;
        rd_base = {rd_r, 2'b00};
        if (rd_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (finish && cur_slot_q == rd_slot_i && rd_base + 6'(k) == idx_q)
                    rd_key_d[(3-k)*32 +: 32] = new_word;
                else
                    rd_key_d[(3-k)*32 +: 32] = words_q[rd_slot_i][rd_base + 6'(k)];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the key buffer is reset too, so no key material survives a reset.
            for (int s = 0; s < NumSlots; s++) begin
                for (int w = 0; w < 60; w++) words_q[s][w] <= '0;
                len_q[s] <= KEY_128;
            end
            valid_q    <= '0;
            state_q    <= IDLE;
            cur_slot_q <= '0;
            cur_len_q  <= KEY_128;
            idx_q      <= '0;
            mod_q      <= '0;
            rcon_q     <= 8'h01;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_key_o   <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; later ones in this block win.
            done_o     <= 1'b0;
            err_o      <= start_err;
            rd_key_o   <= rd_key_d;
            rd_valid_o <= rd_ok;

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        for (int k = 0; k < 8; k++) begin
                            if (k < int'(nk_of(len_dec)))
                                words_q[slot_i][k] <= key_i[(7-k)*32 +: 32];
                        end
                        valid_q[slot_i] <= 1'b0;
                        len_q[slot_i]   <= len_dec;
                        cur_slot_q      <= slot_i;
                        cur_len_q       <= len_dec;
                        idx_q           <= 6'(nk_of(len_dec));
                        mod_q           <= 3'd0;
                        rcon_q          <= 8'h01;
                        busy_o          <= 1'b1;
                        state_q         <= EXPAND;
                    end
                end
                EXPAND: begin
                    words_q[cur_slot_q][idx_q] <= new_word;
                    idx_q <= idx_q + 6'd1;
                    mod_q <= (mod_q == 3'(nk_of(cur_len_q) - 4'd1)) ? 3'd0 : mod_q + 3'd1;
                    if (mod_q == 3'd0)
                        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (last) begin
                        valid_q[cur_slot_q] <= 1'b1;
                        done_o              <= 1'b1;
                        busy_o              <= 1'b0;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Clear overrides both a start and an expansion targeting the same slot
            if (clear_ok) begin
                for (int w = 0; w < 60; w++) words_q[slot_i][w] <= '0;
                valid_q[slot_i] <= 1'b0;
                if (abort) begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/aes_key_sched_buf.md
# aes_key_sched_buf

Iterative, multi-slot AES key schedule engine. It expands a 128/192/256-bit cipher key into the full round-key set, one 32-bit word per cycle, through a single 4-S-box `SubWord` path. Results are stored in a per-slot round-key buffer, so the cipher core can read any round key at random, in encrypt or decrypt order, while another slot is being expanded. It sits between the key sideload/register interface and the AES cipher core. It replaces on-the-fly per-round key expansion.

## Interface
- `AES192Enable`, default 1: when 0, AES-192 requests are rejected with `err_o`.
- `NumSlots`, default 2: number of independent key slots (≥1).
- `SlotW`, default `max(1, clog2(NumSlots))`: width of slot indices.
- `clk_i` input 1: clock; all logic rises on `posedge`.
- `rst_i` input 1: reset, synchronous and active-high.
- `start_i` input 1: start expansion of `key_i` into slot `slot_i`.
- `clear_i` input 1: wipe slot `slot_i`.
- `slot_i` input `SlotW`: target slot for start/clear.
- `key_len_i` input 3: one-hot `001`=AES-128, `010`=AES-192, `100`=AES-256.
- `key_i` input 256: cipher key; word k = `key_i[(7-k)*32 +: 32]`; unused low words ignored.
- `busy_o` output 1: expansion in progress.
- `done_o` output 1: one-cycle pulse when a slot becomes valid.
- `err_o` output 1: one-cycle pulse on a rejected start.
- `rd_slot_i` input `SlotW`: read slot.
- `rd_round_i` input 4: round index 0..Nr.
- `rd_dir_i` input 1: 0 = encrypt order (key r), 1 = decrypt order (key Nr−r).
- `rd_key_o` output 128: round key; word 4r' at `[127:96]` … word 4r'+3 at `[31:0]`.
- `rd_valid_o` output 1: `rd_key_o` holds a valid key.

## Operation
- Parameters per key length: Nk = 4/6/8, Nr = 10/12/14, Nw = 4(Nr+1) = 44/52/60 words. Per-slot storage is 60×32 flops, plus a valid bit and a stored key length.
- States are IDLE and EXPAND.
- **IDLE → EXPAND** when `start_i` is high, `clear_i` is low, and `key_len_i` is legal:
  - Words 0..Nk−1 are written from `key_i`.
  - The slot valid bit is cleared and the key length is latched.
  - The word counter i = Nk; `rcon` = `0x01`.
- **EXPAND**, per cycle, compute word i:
  - temp = w[i−1], w[i] = w[i−Nk] ^ f(temp).
  - If i mod Nk = 0: f = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and `rcon` ← xtime(`rcon`).
  - Else if Nk = 8 and i mod 8 = 4: f = SubWord(temp).
  - Otherwise: f = temp.
  - RotWord rotates left by one byte. SubWord uses four `aes_sbox_lut` instances in encrypt mode.
- **EXPAND → IDLE** after w[Nw−1] is written: set the slot valid bit and pulse `done_o`.
- Illegal start: `key_len_i` not one-hot, or AES-192 with `AES192Enable`=0, or `start_i` while `busy_o`=1. Effect: pulse `err_o`; no state change.
- Clear (any state):
  - Zeroes all 60 words of `slot_i` and clears its valid bit.
  - If EXPAND targets the same slot, the expansion aborts: go to IDLE with no `done_o`.
  - Clear of another slot does not disturb an ongoing expansion.
  - `clear_i` and `start_i` in the same cycle: clear wins and start is ignored, with no `err_o`.
- Read:
  - r' = `rd_dir_i` ? Nr−`rd_round_i` : `rd_round_i`, with Nr taken from the slot's stored length.
  - `rd_valid_o` = slot valid && `rd_round_i` ≤ Nr.
  - When invalid, `rd_key_o` = 0. A slot under expansion or cleared reads invalid.

## Timing
- Reset values:
  - `busy_o`, `done_o`, `err_o`, `rd_valid_o` = 0; `rd_key_o` = 0.
  - All words = 0; all valid bits = 0; `rcon` = `0x01`; state IDLE.
- Reset mid-expansion returns everything to reset values on the next edge.
- Start sampled at edge E:
  - `busy_o` is high from after E through edge E+G, where G = Nw−Nk = 40/46/52.
  - Generated words are written at edges E+1..E+G.
  - After edge E+G: `busy_o`=0, `done_o`=1 for one cycle, and the valid bit is set.
  - A new start is accepted in the `done_o` cycle.
- Read latency is 1 cycle (registered). Address presented at edge N gives data after edge N. A read of the slot completing at edge E+G returns valid data if presented at E+G or later.
- `err_o` is high in the cycle after the offending start edge.

## Test plan
- **AES-128:** start with key `2b7e151628aed2a6abf7158809cf4f3c`, slot 0.
  - Expect `done_o` exactly 41 edges after start, with `busy_o` high 40 cycles.
  - Read round 10, dir 0 → `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - Read round 0, dir 1 → same value.
  - Read round 11 → `rd_valid_o`=0, `rd_key_o`=0.
- **AES-192:** key `8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b`.
  - Expect G=46.
  - Read round 12 → `e98ba06f448c773c8ecc720401002202`.
- **AES-256:** key `603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4` into slot 1.
  - Expect G=52.
  - Read round 14 → `fe4890d1e6188d0b046df344706c631e`.
  - Slot 0's AES-128 keys remain readable during and after.
- **Errors:** `key_len_i`=`011` → `err_o` pulse, `busy_o` stays 0. Start while busy → `err_o` pulse, and the ongoing expansion completes with correct keys.
- **Clear mid-expansion:** at cycle 20 of an AES-128 expansion on slot 0 → no `done_o`, `busy_o` low next cycle, slot 0 reads invalid. A subsequent start succeeds.
- **Reset mid-expansion:** assert `rst_i` during an AES-256 expansion → all outputs 0 next cycle, and all slots read invalid.
